// File: rtl/pulse_stretcher_pkg.sv
// Shared types and elaboration-time helpers for the pulse stretcher.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Bits needed to hold values 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter; done is high whenever the count sits at zero.
module pulse_timer #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches each rising edge of in_event into an ON_TIME-wide pulse separated by
// at least OFF_TIME low cycles, queueing up to PENDING_MAX requests.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int ON_TIME     = 5,
  parameter int OFF_TIME    = 5,
  parameter int PENDING_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in_event,
  output logic out_pulse,
  output logic busy,
  output logic overflow
);

  if (ON_TIME < 1) begin : g_bad_on_time
    $fatal(1, "pulse_stretcher: ON_TIME must be >= 1");
  end
  if (OFF_TIME < 1) begin : g_bad_off_time
    $fatal(1, "pulse_stretcher: OFF_TIME must be >= 1");
  end
  if (PENDING_MAX < 1) begin : g_bad_pending_max
    $fatal(1, "pulse_stretcher: PENDING_MAX must be >= 1");
  end

  localparam int TW = clog2(max2(ON_TIME, OFF_TIME) + 1);
  localparam int PW = clog2(PENDING_MAX + 1);
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_TIME - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_TIME - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(PENDING_MAX);

  state_e        state_q, state_d;
  logic [PW-1:0] pending_q, pending_d;
  logic          prev_q;
  logic          out_pulse_q, busy_q, overflow_q;
  logic          overflow_d;

  logic          edge_det;
  logic          last_gap;
  logic          direct_take;
  logic          pend_inc, pend_dec;
  logic          t_load, t_done;
  logic [TW-1:0] t_val;

  pulse_timer #(
    .W (TW)
  ) u_timer (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (t_load),
    .load_val_i (t_val),
    .done_o     (t_done)
  );

  assign edge_det    = in_event & ~prev_q;
  assign last_gap    = (state_q == GAP) && t_done;
  // An edge on the final gap cycle with nothing queued starts the next pulse itself.
  assign direct_take = last_gap && (pending_q == '0);
  assign pend_inc    = edge_det && (state_q != IDLE) && !direct_take && (pending_q != PEND_MAX);
  assign overflow_d  = edge_det && (state_q != IDLE) && !direct_take && (pending_q == PEND_MAX);
  assign pend_dec    = last_gap && (pending_q != '0);

  always_comb begin
    state_d = state_q;
    t_load  = 1'b0;
    t_val   = '0;
    unique case (state_q)
      IDLE: begin
        if (edge_det) begin
          state_d = ON;
          t_load  = 1'b1;
          t_val   = ON_LOAD;
        end
      end
      ON: begin
        if (t_done) begin
          state_d = GAP;
          t_load  = 1'b1;
          t_val   = OFF_LOAD;
        end
      end
      GAP: begin
        if (t_done) begin
          if ((pending_q != '0) || edge_det) begin
            state_d = ON;
            t_load  = 1'b1;
            t_val   = ON_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    unique case ({pend_inc, pend_dec})
      2'b10:   pending_d = pending_q + 1'b1;
      2'b01:   pending_d = pending_q - 1'b1;
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      prev_q      <= 1'b1;
      out_pulse_q <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      prev_q      <= in_event;
      out_pulse_q <= (state_d == ON);
      busy_q      <= (state_d != IDLE) || (pending_d != '0);
      overflow_q  <= overflow_d;
    end
  end

  assign out_pulse = out_pulse_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Randomised and directed bench for pulse_stretcher against a schedule-based reference model.
module tb_pulse_stretcher;

  localparam int ON   = 5;
  localparam int OFF  = 5;
  localparam int PMAX = 3;

  logic clk;
  logic rst;
  logic in_event;
  logic out_pulse;
  logic busy;
  logic overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: start cycle of the latest scheduled pulse, queued count, etc.
  int t      = 0;
  int m_s    = -1000;
  int m_pend = 0;
  bit m_prev = 1'b1;
  bit m_ovf  = 1'b0;

  pulse_stretcher #(
    .ON_TIME     (ON),
    .OFF_TIME    (OFF),
    .PENDING_MAX (PMAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_event  (in_event),
    .out_pulse (out_pulse),
    .busy      (busy),
    .overflow  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic bit exp_out();
    return (t >= m_s) && (t < m_s + ON);
  endfunction

  function automatic bit exp_busy();
    return ((t >= m_s) && (t <= m_s + ON + OFF - 1)) || (m_pend > 0);
  endfunction

  task automatic model_reset();
    m_s    = -1000;
    m_pend = 0;
    m_prev = 1'b1;
    m_ovf  = 1'b0;
  endtask

  // Drive one cycle's input from a negedge, advance the model at the posedge,
  // and return at the following negedge where outputs belong to cycle t.
  task automatic cycle(input logic ev);
    bit e;
    bit active;
    int last;
    int p0;
    in_event = ev;
    @(posedge clk);
    e      = ev && !m_prev;
    m_prev = ev;
    last   = m_s + ON + OFF - 1;
    active = (t >= m_s) && (t <= last);
    p0     = m_pend;
    m_ovf  = 1'b0;
    if (!active) begin
      if (e) m_s = t + 1;
    end else begin
      if (t == last && (p0 > 0 || e)) m_s = t + 1;
      if (t == last && p0 > 0) m_pend = m_pend - 1;
      if (e && !(t == last && p0 == 0)) begin
        if (p0 < PMAX) m_pend = m_pend + 1;
        else m_ovf = 1'b1;
      end
    end
    t = t + 1;
    @(negedge clk);
  endtask

  // Independent run-length monitor on out_pulse.
  int  mon_hi   = 0;
  int  mon_lo   = 0;
  bit  mon_seen = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      mon_hi   = 0;
      mon_lo   = 0;
      mon_seen = 1'b0;
    end else if (out_pulse === 1'b1) begin
      if (mon_hi == 0 && mon_seen) begin
        checks++;
        if (mon_lo < OFF) begin
          errors++;
          $display("FAIL monitor_gap: low run %0d, required >= %0d (t=%0d)", mon_lo, OFF, t);
        end
      end
      mon_hi++;
      mon_lo = 0;
    end else begin
      if (mon_hi != 0) begin
        checks++;
        if (mon_hi != ON) begin
          errors++;
          $display("FAIL monitor_width: high run %0d, required %0d (t=%0d)", mon_hi, ON, t);
        end
        mon_seen = 1'b1;
      end
      mon_hi = 0;
      mon_lo++;
    end
  end

  task automatic test_reset();
    rst      = 1'b1;
    in_event = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks += 3;
    if (out_pulse !== 1'b0) begin errors++; $display("FAIL reset_out: got %b exp 0", out_pulse); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b exp 0", overflow); end
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1);
      checks += 3;
      if (out_pulse !== 1'b0) begin errors++; $display("FAIL reset_hold_out k=%0d: got %b exp 0", k, out_pulse); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_hold_busy k=%0d: got %b exp 0", k, busy); end
      if (overflow !== 1'b0) begin errors++; $display("FAIL reset_hold_ovf k=%0d: got %b exp 0", k, overflow); end
    end
    for (int k = 0; k < 5; k++) cycle(1'b0);
  endtask

  task automatic test_single();
    bit eo, eb;
    for (int k = 0; k < 40; k++) begin
      cycle(k == 10);
      eo = (k + 1 >= 11) && (k + 1 <= 15);
      eb = (k + 1 >= 11) && (k + 1 <= 20);
      checks += 5;
      if (out_pulse !== exp_out()) begin errors++; $display("FAIL single_out_model k=%0d: got %b exp %b", k, out_pulse, exp_out()); end
      if (busy !== exp_busy()) begin errors++; $display("FAIL single_busy_model k=%0d: got %b exp %b", k, busy, exp_busy()); end
      if (overflow !== m_ovf) begin errors++; $display("FAIL single_ovf k=%0d: got %b exp %b", k, overflow, m_ovf); end
      if (out_pulse !== eo) begin errors++; $display("FAIL single_out k=%0d: got %b exp %b", k + 1, out_pulse, eo); end
      if (busy !== eb) begin errors++; $display("FAIL single_busy k=%0d: got %b exp %b", k + 1, busy, eb); end
    end
  endtask

  task automatic test_two_edges();
    bit eo;
    for (int k = 0; k < 45; k++) begin
      cycle(k == 10 || k == 13);
      eo = ((k + 1 >= 11) && (k + 1 <= 15)) || ((k + 1 >= 21) && (k + 1 <= 25));
      checks += 4;
      if (out_pulse !== exp_out()) begin errors++; $display("FAIL two_out_model k=%0d: got %b exp %b", k, out_pulse, exp_out()); end
      if (busy !== exp_busy()) begin errors++; $display("FAIL two_busy_model k=%0d: got %b exp %b", k, busy, exp_busy()); end
      if (overflow !== 1'b0) begin errors++; $display("FAIL two_ovf k=%0d: got %b exp 0", k, overflow); end
      if (out_pulse !== eo) begin errors++; $display("FAIL two_out k=%0d: got %b exp %b", k + 1, out_pulse, eo); end
    end
  endtask

  task automatic test_overflow();
    int  pulses;
    int  ovfs;
    bit  last_out;
    bit  ev;
    pulses   = 0;
    ovfs     = 0;
    last_out = 1'b0;
    for (int k = 0; k < 70; k++) begin
      ev = (k == 10 || k == 12 || k == 14 || k == 16 || k == 18);
      cycle(ev);
      checks += 4;
      if (out_pulse !== exp_out()) begin errors++; $display("FAIL ovf_out_model k=%0d: got %b exp %b", k, out_pulse, exp_out()); end
      if (busy !== exp_busy()) begin errors++; $display("FAIL ovf_busy_model k=%0d: got %b exp %b", k, busy, exp_busy()); end
      if (overflow !== m_ovf) begin errors++; $display("FAIL ovf_model k=%0d: got %b exp %b", k, overflow, m_ovf); end
      if (overflow !== (k + 1 == 19)) begin errors++; $display("FAIL ovf_strobe k=%0d: got %b exp %b", k + 1, overflow, (k + 1 == 19)); end
      if (out_pulse === 1'b1 && !last_out) pulses++;
      if (overflow === 1'b1) ovfs++;
      last_out = (out_pulse === 1'b1);
    end
    checks += 2;
    if (pulses != 4) begin errors++; $display("FAIL ovf_pulse_count: got %0d exp 4", pulses); end
    if (ovfs != 1) begin errors++; $display("FAIL ovf_strobe_count: got %0d exp 1", ovfs); end
  endtask

  task automatic test_last_gap();
    bit eo, eb;
    for (int k = 0; k < 45; k++) begin
      cycle(k == 10 || k == 20);
      eo = ((k + 1 >= 11) && (k + 1 <= 15)) || ((k + 1 >= 21) && (k + 1 <= 25));
      eb = (k + 1 >= 11) && (k + 1 <= 30);
      checks += 4;
      if (out_pulse !== exp_out()) begin errors++; $display("FAIL lastgap_out_model k=%0d: got %b exp %b", k, out_pulse, exp_out()); end
      if (overflow !== 1'b0) begin errors++; $display("FAIL lastgap_ovf k=%0d: got %b exp 0", k, overflow); end
      if (out_pulse !== eo) begin errors++; $display("FAIL lastgap_out k=%0d: got %b exp %b", k + 1, out_pulse, eo); end
      if (busy !== eb) begin errors++; $display("FAIL lastgap_busy k=%0d: got %b exp %b", k + 1, busy, eb); end
    end
  endtask

  task automatic test_reset_mid_on();
    for (int k = 0; k < 13; k++) begin
      cycle(k == 8 || k == 10 || k == 12);
      checks += 2;
      if (out_pulse !== exp_out()) begin errors++; $display("FAIL midrst_pre_out k=%0d: got %b exp %b", k, out_pulse, exp_out()); end
      if (busy !== exp_busy()) begin errors++; $display("FAIL midrst_pre_busy k=%0d: got %b exp %b", k, busy, exp_busy()); end
    end
    in_event = 1'b0;
    checks += 1;
    if (out_pulse !== 1'b1) begin errors++; $display("FAIL midrst_on_before: got %b exp 1", out_pulse); end
    #2 rst = 1'b0;
    #1;
    checks += 3;
    if (out_pulse !== 1'b0) begin errors++; $display("FAIL midrst_out_async: got %b exp 0", out_pulse); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_async: got %b exp 0", busy); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf_async: got %b exp 0", overflow); end
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cycle(1'b0);
      checks += 3;
      if (out_pulse !== 1'b0) begin errors++; $display("FAIL midrst_post_out k=%0d: got %b exp 0", k, out_pulse); end
      if (busy !== 1'b0) begin errors++; $display("FAIL midrst_post_busy k=%0d: got %b exp 0", k, busy); end
      if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_post_ovf k=%0d: got %b exp 0", k, overflow); end
    end
  endtask

  task automatic test_random();
    int dens;
    for (int blk = 0; blk < 6; blk++) begin
      dens = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 35 : 70);
      for (int k = 0; k < 500; k++) begin
        cycle($urandom_range(0, 99) < dens);
        checks += 3;
        if (out_pulse !== exp_out()) begin errors++; $display("FAIL rand_out t=%0d: got %b exp %b", t, out_pulse, exp_out()); end
        if (busy !== exp_busy()) begin errors++; $display("FAIL rand_busy t=%0d: got %b exp %b", t, busy, exp_busy()); end
        if (overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf t=%0d: got %b exp %b", t, overflow, m_ovf); end
      end
    end
    for (int k = 0; k < 40; k++) cycle(1'b0);
    checks += 1;
    if (busy !== 1'b0) begin errors++; $display("FAIL rand_drain_busy: got %b exp 0", busy); end
  endtask

  initial begin
    rst      = 1'b1;
    in_event = 1'b0;
    test_reset();
    test_single();
    test_two_edges();
    test_overflow();
    test_last_gap();
    test_reset_mid_on();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 Clocking: one clock; reset is asynchronous and active-low.
REQ-002 Parameter ON_TIME, default 5, output high duration in clk cycles (legal range >= 1).
REQ-003 Parameter OFF_TIME, default 5, minimum output low gap in clk cycles between pulses (legal range >= 1).
REQ-004 Parameter PENDING_MAX, default 3, depth of the request queue counter (legal range >= 1).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 in_event  input  1  request line, synchronous to clk; each rising edge is one request.
REQ-008 out_pulse  output  1  registered stretched pulse.
REQ-009 busy  output  1  high while state != IDLE or pending != 0.
REQ-010 overflow  output  1  registered one-cycle strobe when a request is dropped.

Function
REQ-011 Edge detect: edge = in_event & ~prev, where prev is in_event registered.
REQ-012 States SHALL be IDLE, ON and GAP. Encoding and transitions are as follows.
REQ-013 Out of IDLE: edge sampled in cycle N -> ON; out_pulse high from cycle N+1.
REQ-014 ON: out_pulse high for exactly ON_TIME cycles. The state then moves to GAP.
REQ-015 GAP: out_pulse low for exactly OFF_TIME cycles.
  - On the last GAP cycle, if pending > 0 or an edge is present, next state is ON, with no IDLE cycle.
  - Otherwise next state is IDLE.
REQ-016 Edge while in ON or GAP, with pending < PENDING_MAX: pending increments by 1.
REQ-017 Edge while pending == PENDING_MAX (and state != IDLE): request dropped. overflow is high the next cycle for one cycle. pending is unchanged.
REQ-018 GAP to ON transition consuming a queued request: pending decrements by 1.
REQ-019 Edge on the last GAP cycle with pending > 0: increment and decrement cancel, so pending is unchanged. Any overflow check uses the pre-update value.
REQ-020 Edge on the last GAP cycle with pending == 0: consumed directly by the new ON; pending stays 0.
REQ-021 out_pulse SHALL never be high for fewer or more than ON_TIME consecutive cycles (no runts).
REQ-022 out_pulse SHALL never be low for fewer than OFF_TIME cycles between two pulses.
REQ-023 Counter widths: the timer is clog2(max(ON_TIME,OFF_TIME)+1) bits and pending is clog2(PENDING_MAX+1) bits. Neither SHALL wrap.

Reset
REQ-024 While rst is low, all of the following hold immediately (asynchronously):
  - state = IDLE, timer = 0, pending = 0;
  - out_pulse = 0, busy = 0, overflow = 0;
  - prev = 1.
REQ-025 Because prev resets to 1, in_event held high across reset release SHALL NOT generate a request.
REQ-026 Reset mid-ON or mid-GAP: out_pulse drops at once and queued requests are discarded.

Structure
REQ-027 A shared package SHALL hold:
  - the state enumeration (IDLE/ON/GAP);
  - the clog2 width function.
REQ-028 One sub-module, pulse_timer, SHALL be used.
  - Behaviour: loadable down-counter with load value input and a done flag.
  - Instantiation: once, shared by the ON and GAP phases.
REQ-029 Parameter legality checks SHALL be done at elaboration and SHALL stop elaboration on an illegal value.

Verification (defaults: ON_TIME=5, OFF_TIME=5, PENDING_MAX=3)
REQ-030 Reset scenario: in_event held high before, during and after rst release -> out_pulse, busy and overflow remain 0 for 20 cycles.
REQ-031 Single edge sampled at cycle 10 -> out_pulse high for cycles 11-15 and low from cycle 16; busy low from cycle 21.
REQ-032 Edges at cycles 10 and 13 -> out_pulse high 11-15, low 16-20, high 21-25; pending peaks at 1.
REQ-033 Five edges at cycles 10, 12, 14, 16, 18 -> three requests queued, fifth dropped with overflow high at cycle 19 only, exactly 4 pulses each 5 cycles wide with 5-cycle gaps.
REQ-034 Edge on the last GAP cycle (cycle 20 after an edge at 10) -> second pulse high 21-25, pending stays 0.
REQ-035 rst asserted at cycle 13 during ON with pending = 2 -> out_pulse 0 at once; after release no further pulses without new edges.
REQ-036 All scenarios SHALL include a monitor that fails on any high run != ON_TIME or any inter-pulse low run < OFF_TIME.
